// File: rtl/lut_gen_pkg.sv
// Shared types and helpers for the parametrised bit-bus LUT block.
package lut_gen_pkg;

  typedef enum logic [1:0] {
    ModeLvl    = 2'd0,
    ModeRise   = 2'd1,
    ModeFall   = 2'd2,
    ModeEither = 2'd3
  } mode_e;

  localparam int unsigned MaxInputs = 6;

  function automatic int unsigned tbl_w(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/lut_gen_cond.sv
// Per-input conditioner: remembers the previous input level and derives the
// level/edge-qualified index bit used for the truth-table lookup.
module lut_gen_cond
  import lut_gen_pkg::*;
(
  input  logic  clk_i,
  input  logic  reset_n_i,
  input  logic  inp_i,
  input  mode_e mode_i,
  input  logic  primed_i,
  output logic  c_o
);

  logic prev_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= inp_i;
    end
  end

  // Edge modes are gated by primed_i so stale history never produces a pulse.
  always_comb begin
    c_o = 1'b0;
    unique case (mode_i)
      ModeLvl:    c_o = inp_i;
      ModeRise:   c_o = primed_i & inp_i & ~prev_q;
      ModeFall:   c_o = primed_i & ~inp_i & prev_q;
      ModeEither: c_o = primed_i & (inp_i ^ prev_q);
      default:    c_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/lut_gen.sv
// Parametrised LUT over NUM_INPUTS conditioned bit-bus inputs with a registered output.
// Optional output rising-edge counter enabled by defining LUT_GEN_COUNT_EN.
module lut_gen
  import lut_gen_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 5,
  localparam int unsigned TBL_W = tbl_w(NUM_INPUTS)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [NUM_INPUTS-1:0]   inp_i,
  input  logic [TBL_W-1:0]        FUNC,
  input  logic                    FUNC_WSTB,
  input  logic [2*NUM_INPUTS-1:0] MODE,
  input  logic                    MODE_WSTB,
`ifdef LUT_GEN_COUNT_EN
  output logic [31:0]             count_o,
`endif
  output logic                    out_o
);

  logic [TBL_W-1:0]        func_q;
  logic [2*NUM_INPUTS-1:0] mode_q;
  logic                    primed_q, primed_d;
  logic                    out_q, out_d;
  logic [NUM_INPUTS-1:0]   c;

  // A mode write drops primed for one cycle so edges spanning the change are ignored.
  assign primed_d = ~MODE_WSTB;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      func_q   <= '0;
      mode_q   <= '0;
      primed_q <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      if (FUNC_WSTB) func_q <= FUNC;
      if (MODE_WSTB) mode_q <= MODE;
      primed_q <= primed_d;
      out_q    <= out_d;
    end
  end

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : gen_cond
    lut_gen_cond u_cond (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .inp_i     (inp_i[i]),
      .mode_i    (mode_e'(mode_q[2*i +: 2])),
      .primed_i  (primed_q),
      .c_o       (c[i])
    );
  end

  always_comb begin
    out_d = func_q[c];
  end

  assign out_o = out_q;

`ifdef LUT_GEN_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else if (FUNC_WSTB || MODE_WSTB) begin
      count_q <= '0;
    end else if (out_d && !out_q) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count_o = count_q;
`endif

endmodule
